sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter HADDR_WIDTH, default 24, host address width (bank+row+col), equal to sdram_controller HADDR_WIDTH.
REQ-002 Parameter TIMEOUT, default 255 (8-bit), max cycles spent in ISSUE or WAIT before abort.
REQ-003 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 pN_req input 1 (N=0,1): request; held high, with pN_we/pN_addr/pN_wdata stable, until pN_ack.
REQ-005 pN_we input 1: 1 = write, 0 = read.
REQ-006 pN_addr input HADDR_WIDTH: host address.
REQ-007 pN_wdata input 16: write data.
REQ-008 pN_ack output 1: one-cycle completion pulse.
REQ-009 pN_rdata output 16: read data, valid when pN_rvalid.
REQ-010 pN_rvalid output 1: one-cycle read-data strobe.
REQ-011 timeout_err output 1: one-cycle pulse on aborted transaction.
REQ-012 sd_wr_addr/sd_rd_addr output HADDR_WIDTH; sd_wr_data output 16; sd_wr_enable/sd_rd_enable output 1: drive controller inputs.
REQ-013 sd_rd_data input 16, sd_rd_ready input 1, sd_busy input 1: controller outputs.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: if any pN_req, grant one port; on both, grant port != last_grant; latch we/addr/wdata of grantee; go ISSUE next cycle.
REQ-017 last_grant SHALL update on every grant.
REQ-018 ISSUE: assert sd_rd_enable (read) or sd_wr_enable (write) continuously; sd_rd_addr and sd_wr_addr both carry latched address; sd_wr_data latched data.
REQ-019 ISSUE: enable SHALL stay high until sd_busy sampled 1 (covers controller refresh ignoring enable); then drop enable next cycle, go WAIT.
REQ-020 Address/data outputs SHALL stay stable from ISSUE entry through DONE.
REQ-021 WAIT read: on sd_rd_ready=1, capture sd_rd_data, go DONE.
REQ-022 WAIT write: on sd_busy=0, go DONE.
REQ-023 DONE lasts exactly one cycle: grantee pN_ack=1; for reads also pN_rvalid=1 with captured pN_rdata; then IDLE.
REQ-024 Non-granted port's ack/rvalid SHALL stay 0; pN_rdata holds last value.
REQ-025 Requests SHALL be sampled only in IDLE; req changes in other states are ignored.
REQ-026 8-bit timer SHALL clear on entry to ISSUE and to WAIT and count each cycle in those states.
REQ-027 Timer reaching TIMEOUT SHALL: drop enables, pulse timeout_err and grantee pN_ack (pN_rvalid=0) in the DONE cycle, return IDLE.
REQ-028 Minimum latency: req high at cycle n (IDLE) -> enable at n+1 -> ack no earlier than n+4.
REQ-029 One transaction in flight at a time; no pipelining.

Reset
REQ-030 rst=1 at clk edge SHALL force: state IDLE, last_grant=1 (port 0 wins first tie), all enables/acks/rvalid/timeout_err 0, pN_rdata 0, latched addr/data 0, timer 0.
REQ-031 Reset mid-transaction SHALL abort immediately, without ack; enables low the cycle after the reset edge.

Verification
REQ-032 Single write p0 addr 0x012345 data 0xBEEF, behavioural controller -> sd_wr_enable high until busy, p0_ack once, sd_wr_data=0xBEEF throughout.
REQ-033 Write then read p1 same addr -> p1_rvalid+p1_ack same cycle, p1_rdata=0xBEEF.
REQ-034 p0/p1 requesting simultaneously after reset, 4 transactions each -> grants alternate 0,1,0,1...; no ack to non-grantee.
REQ-035 Read issued while controller in refresh (busy low for 12 cycles) -> sd_rd_enable held 12+ cycles, read completes with correct data.
REQ-036 sd_busy tied 0 -> after 255 ISSUE cycles, timeout_err and p0_ack pulse once, p0_rvalid 0, back to IDLE.
REQ-037 rst asserted in WAIT -> no ack, enables 0, next request serviced normally with port 0 winning ties.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-port alternating-priority arbiter in front of an SDRAM controller.
// One transaction in flight at a time; every output is a flop.
module sdram_port_arbiter #(
  parameter int         HADDR_WIDTH = 24,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [15:0]            p0_wdata,
  output logic                   p0_ack,
  output logic [15:0]            p0_rdata,
  output logic                   p0_rvalid,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [15:0]            p1_wdata,
  output logic                   p1_ack,
  output logic [15:0]            p1_rdata,
  output logic                   p1_rvalid,
  output logic                   timeout_err,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic [15:0]            sd_wr_data,
  output logic                   sd_wr_enable,
  output logic                   sd_rd_enable,
  input  logic [15:0]            sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t state, state_d;

  logic                   last_grant, last_d;
  logic                   gnt, gnt_d;
  logic                   we_q, we_d;
  logic [HADDR_WIDTH-1:0] addr_d;
  logic [15:0]            wdata_d;
  logic [7:0]             timer, timer_d;
  logic [7:0]             timer_inc;
  logic                   tmo, pick, fin;
  logic                   wr_en_d, rd_en_d;
  logic                   ack0_d, ack1_d;
  logic                   rv0_d, rv1_d;
  logic                   terr_d;
  logic [15:0]            rdata0_d, rdata1_d;

  assign timer_inc = timer + 8'd1;
  assign tmo       = (timer_inc == TIMEOUT);
  assign pick      = (p0_req & p1_req) ? ~last_grant : p1_req;
  assign fin       = we_q ? ~sd_busy : sd_rd_ready;

  always_comb begin
    state_d  = state;
    last_d   = last_grant;
    gnt_d    = gnt;
    we_d     = we_q;
    addr_d   = sd_wr_addr;
    wdata_d  = sd_wr_data;
    timer_d  = timer;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    terr_d   = 1'b0;
    rdata0_d = p0_rdata;
    rdata1_d = p1_rdata;
    unique case (state)
      IDLE: begin
        if (p0_req | p1_req) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? p1_we : p0_we;
          addr_d  = pick ? p1_addr : p0_addr;
          wdata_d = pick ? p1_wdata : p0_wdata;
          wr_en_d = we_d;
          rd_en_d = ~we_d;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_inc;
        // Busy is the only proof the controller took the command;
        // a refresh silently drops it, so keep the enable up.
        if (sd_busy) begin
          timer_d = '0;
          state_d = WAIT;
        end else if (tmo) begin
          state_d = DONE;
          terr_d  = 1'b1;
          ack0_d  = ~gnt;
          ack1_d  = gnt;
        end else begin
          wr_en_d = we_q;
          rd_en_d = ~we_q;
        end
      end
      WAIT: begin
        timer_d = timer_inc;
        if (fin | tmo) begin
          state_d = DONE;
          ack0_d  = ~gnt;
          ack1_d  = gnt;
          terr_d  = ~fin;
          if (fin & ~we_q) begin
            rv0_d = ~gnt;
            rv1_d = gnt;
            if (gnt) rdata1_d = sd_rd_data;
            else     rdata0_d = sd_rd_data;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      we_q         <= 1'b0;
      timer        <= '0;
      sd_wr_addr   <= '0;
      sd_rd_addr   <= '0;
      sd_wr_data   <= '0;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      last_grant   <= last_d;
      gnt          <= gnt_d;
      we_q         <= we_d;
      timer        <= timer_d;
      sd_wr_addr   <= addr_d;
      sd_rd_addr   <= addr_d;
      sd_wr_data   <= wdata_d;
      sd_wr_enable <= wr_en_d;
      sd_rd_enable <= rd_en_d;
      p0_ack       <= ack0_d;
      p1_ack       <= ack1_d;
      p0_rvalid    <= rv0_d;
      p1_rvalid    <= rv1_d;
      p0_rdata     <= rdata0_d;
      p1_rdata     <= rdata1_d;
      timeout_err  <= terr_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: vector table, corner sequences, random rounds
// against an arbitration/memory model, with a behavioural SDRAM controller.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [23:0] p0_addr = '0;
  logic [15:0] p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [23:0] p1_addr = '0;
  logic [15:0] p1_wdata = '0;
  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        timeout_err;
  logic [23:0] sd_wr_addr, sd_rd_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_enable, sd_rd_enable;
  logic [15:0] sd_rd_data = '0;
  logic        sd_rd_ready = 1'b0;
  logic        sd_busy = 1'b0;

  sdram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .p1_rvalid(p1_rvalid),
    .timeout_err(timeout_err),
    .sd_wr_addr(sd_wr_addr), .sd_rd_addr(sd_rd_addr),
    .sd_wr_data(sd_wr_data),
    .sd_wr_enable(sd_wr_enable),
    .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data),
    .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy)
  );

  always #5 clk = ~clk;

  // Controller: accepts an enable, stays busy ctl_lat cycles; a read ends
  // with rd_ready. Refresh windows and tie0 make it ignore enables.
  int          ctl_lat = 1;
  bit          tie0 = 1'b0;
  int          ctl_cyc = 0;
  int          refr_until = 0;
  int          cnt = 0;
  logic        cur_we = 1'b0;
  logic [7:0]  cur_a = '0;
  logic [15:0] cmem [256];

  always @(posedge clk) begin
    ctl_cyc <= ctl_cyc + 1;
    sd_rd_ready <= 1'b0;
    if (rst) begin
      sd_busy <= 1'b0;
      cnt <= 0;
      for (int i = 0; i < 256; i++) cmem[i] <= 16'h0;
    end else if (tie0 || ctl_cyc < refr_until) begin
      sd_busy <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        sd_busy <= 1'b0;
        if (!cur_we) begin
          sd_rd_ready <= 1'b1;
          sd_rd_data <= cmem[cur_a];
        end
      end
    end else if (sd_wr_enable || sd_rd_enable) begin
      sd_busy <= 1'b1;
      cnt <= ctl_lat;
      cur_we <= sd_wr_enable;
      cur_a <= sd_wr_enable ? sd_wr_addr[7:0] : sd_rd_addr[7:0];
      if (sd_wr_enable) cmem[sd_wr_addr[7:0]] <= sd_wr_data;
    end
  end

  typedef struct {
    logic [1:0]  rq;
    logic        w0, w1;
    logic [23:0] a0, a1;
    logic [15:0] d0, d1;
    logic        first;
    logic [15:0] e0, e1;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return 128'({p0_ack, p1_ack, p0_rvalid, p1_rvalid, timeout_err,
                 sd_wr_enable, sd_rd_enable, p0_rdata, p1_rdata,
                 sd_wr_addr, sd_rd_addr, sd_wr_data});
  endfunction

  task automatic run_round(input vec_t v, output int en_cyc);
    logic [1:0]  pend;
    logic        cur, wc;
    logic [23:0] ac;
    logic [15:0] dc, ec;
    int          lat, k;
    en_cyc = 0;
    @(negedge clk);
    p0_req = v.rq[0]; p0_we = v.w0;
    p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.rq[1]; p1_we = v.w1;
    p1_addr = v.a1; p1_wdata = v.d1;
    pend = v.rq; cur = v.first;
    lat = 0; k = 0;
    while (pend != 2'b00 && k < 1000) begin
      @(negedge clk);
      k++; lat++;
      wc = cur ? v.w1 : v.w0;
      ac = cur ? v.a1 : v.a0;
      dc = cur ? v.d1 : v.d0;
      ec = cur ? v.e1 : v.e0;
      if (sd_wr_enable | sd_rd_enable) begin
        en_cyc++;
        chk("issue_bus",
            128'({sd_wr_enable, sd_rd_enable, sd_wr_addr,
                  sd_rd_addr, wc ? sd_wr_data : 16'h0}),
            128'({wc, ~wc, ac, ac, wc ? dc : 16'h0}));
      end
      if (p0_ack | p1_ack | timeout_err) begin
        chk("ack_port", 128'({timeout_err, p1_ack, p0_ack}),
            128'({1'b0, cur, ~cur}));
        chk("rvalid", 128'({p1_rvalid, p0_rvalid}),
            128'({cur & ~wc, ~cur & ~wc}));
        chk("latency_ge4", 128'(lat >= 4), 128'd1);
        if (!wc)
          chk("rdata", 128'(cur ? p1_rdata : p0_rdata), 128'(ec));
        if (cur) p1_req = 1'b0;
        else     p0_req = 1'b0;
        pend[cur] = 1'b0;
        cur = ~cur;
        lat = 0;
      end
    end
    if (pend != 2'b00) chk("round_done", 128'(pend), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [6];
    vec_t        tv;
    logic [23:0] pool [6];
    logic [15:0] rmem [logic [23:0]];
    bit          m_last;
    int          en, k;
    logic        seen, f;

    tbl[0] = '{2'b01, 1'b1, 1'b0, 24'h012345, 24'h0,
               16'hBEEF, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[1] = '{2'b10, 1'b0, 1'b0, 24'h0, 24'h012345,
               16'h0, 16'h0, 1'b1, 16'h0, 16'hBEEF};
    tbl[2] = '{2'b11, 1'b1, 1'b1, 24'h000110, 24'h000220,
               16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0};
    tbl[3] = '{2'b11, 1'b0, 1'b1, 24'h000220, 24'h000110,
               16'h0, 16'h3333, 1'b0, 16'h2222, 16'h0};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 24'h000110, 24'h012345,
               16'h0, 16'h0, 1'b0, 16'h3333, 16'hBEEF};
    tbl[5] = '{2'b11, 1'b1, 1'b0, 24'h000330, 24'h000330,
               16'h4444, 16'h0, 1'b0, 16'h0, 16'h4444};
    pool = '{24'h7F0001, 24'h7F0002, 24'hC00013,
             24'h0A0A0A, 24'hFFFFFE, 24'h355AA3};

    repeat (3) @(negedge clk);
    chk("reset_state", all_out(), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_round(tbl[i], en);

    // Read during a refresh that swallows the enable.
    tv = '{2'b01, 1'b0, 1'b0, 24'h012345, 24'h0,
           16'h0, 16'h0, 1'b0, 16'hBEEF, 16'h0};
    refr_until = ctl_cyc + 14;
    run_round(tv, en);
    chk("refresh_en_hold", 128'(en >= 12), 128'd1);

    // Controller never busy: abort after TIMEOUT issue cycles.
    tie0 = 1'b1;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000440;
    en = 0; k = 0;
    while (!timeout_err && !p0_ack && k < 400) begin
      @(negedge clk);
      k++;
      if (sd_rd_enable) en++;
    end
    chk("tmo_en_cycles", 128'(en), 128'd255);
    chk("tmo_pulse",
        128'({timeout_err, p0_ack, p0_rvalid, p1_ack,
              p1_rvalid, sd_rd_enable, sd_wr_enable}),
        128'(7'b1100000));
    p0_req = 1'b0;
    @(negedge clk);
    chk("tmo_once", 128'({timeout_err, p0_ack}), 128'd0);
    tie0 = 1'b0;

    // Reset while waiting on a long write.
    ctl_lat = 10;
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b1;
    p1_addr = 24'hABCDEF; p1_wdata = 16'h5A5A;
    k = 0;
    while (!sd_wr_enable && k < 50) begin
      @(negedge clk); k++;
    end
    while (sd_wr_enable && k < 100) begin
      @(negedge clk); k++;
    end
    rst = 1'b1; p1_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_wait", all_out(), 128'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | p0_ack | p1_ack | sd_wr_enable | sd_rd_enable;
    end
    chk("no_ack_after_rst", 128'(seen), 128'd0);
    ctl_lat = 1;
    tv = '{2'b11, 1'b1, 1'b1, 24'h000550, 24'h000660,
           16'h0505, 16'h0606, 1'b0, 16'h0, 16'h0};
    run_round(tv, en);

    // Random rounds against the arbitration + memory model.
    m_last = 1'b1;
    for (int r = 0; r < 40; r++) begin
      tv.rq = 2'($urandom_range(1, 3));
      tv.w0 = 1'($urandom_range(0, 1));
      tv.w1 = 1'($urandom_range(0, 1));
      tv.a0 = pool[$urandom_range(0, 5)];
      tv.a1 = pool[$urandom_range(0, 5)];
      tv.d0 = 16'($urandom);
      tv.d1 = 16'($urandom);
      tv.first = (tv.rq == 2'b11) ? ~m_last : tv.rq[1];
      tv.e0 = 16'h0;
      tv.e1 = 16'h0;
      for (int s = 0; s < 2; s++) begin
        f = (s == 0) ? tv.first : ~tv.first;
        if (tv.rq[f]) begin
          if (f ? tv.w1 : tv.w0)
            rmem[f ? tv.a1 : tv.a0] = f ? tv.d1 : tv.d0;
          else if (f)
            tv.e1 = rmem.exists(tv.a1) ? rmem[tv.a1] : 16'h0;
          else
            tv.e0 = rmem.exists(tv.a0) ? rmem[tv.a0] : 16'h0;
          m_last = f;
        end
      end
      ctl_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0)
        refr_until = ctl_cyc + $urandom_range(2, 8);
      run_round(tv, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
